// File: rtl/dice_pkg.sv
// Shared types and constants for the dice roller datapath.
package dice_pkg;

  typedef enum logic [1:0] {
    IDLE,
    PRESS_CHK,
    HELD,
    REL_CHK
  } roll_state_t;

  localparam int DICE_DEBOUNCE_DEFAULT = 500000;
  localparam int DICE_CLK_HZ           = 50000000;

endpackage

// File: rtl/sync2.sv
// Generic two-flop synchroniser for asynchronous pin inputs.
module sync2 #(
  parameter logic RESET_VAL = 1'b0
) (
  input  logic clk,
  input  logic reset_n,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      meta <= RESET_VAL;
      q    <= RESET_VAL;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/roll_conditioner.sv
// Roll button conditioner: synchronise, debounce, one roll pulse per accepted press.
// Optional auto-repeat while held is enabled by defining ROLL_REPEAT_EN.
module roll_conditioner
  import dice_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DICE_DEBOUNCE_DEFAULT,
  parameter int BTN_ACTIVE_LOW  = 1,
  parameter int REPEAT_DELAY    = 25000000,
  parameter int REPEAT_PERIOD   = 5000000
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        btn_raw,
  output logic        roll,
  output logic        btn_level,
  output logic [7:0]  press_count,
  output roll_state_t state_dbg
);

  localparam logic ACT_LOW = (BTN_ACTIVE_LOW != 0);
  localparam int   CW      = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  roll_state_t   state, state_nxt;
  logic [CW-1:0] cnt;
  logic          btn_sync;
  logic          btn_s;
  logic          accept;
  logic          rep_fire;
  logic          fire;

  // Synchroniser resets to the released pin level so reset never looks like a press.
  sync2 #(.RESET_VAL(ACT_LOW)) u_sync (
    .clk     (clk),
    .reset_n (reset_n),
    .d       (btn_raw),
    .q       (btn_sync)
  );

  assign btn_s     = btn_sync ^ ACT_LOW;
  assign state_dbg = state;
  assign fire      = accept | rep_fire;

  always_comb begin
    state_nxt = state;
    accept    = 1'b0;
    case (state)
      IDLE: begin
        if (btn_s) state_nxt = PRESS_CHK;
      end
      PRESS_CHK: begin
        if (!btn_s) begin
          state_nxt = IDLE;
        end else if (cnt == CNT_LAST) begin
          state_nxt = HELD;
          accept    = 1'b1;
        end
      end
      HELD: begin
        if (!btn_s) state_nxt = REL_CHK;
      end
      REL_CHK: begin
        if (btn_s) begin
          state_nxt = HELD;
        end else if (cnt == CNT_LAST) begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Debounce counter restarts on every state change and saturates otherwise.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      if (state_nxt != state) begin
        cnt <= '0;
      end else if (cnt != CNT_LAST) begin
        cnt <= cnt + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      roll        <= 1'b0;
      btn_level   <= 1'b0;
      press_count <= 8'd0;
    end else begin
      roll        <= fire;
      btn_level   <= (state_nxt == HELD) || (state_nxt == REL_CHK);
      press_count <= press_count + {7'd0, fire};
    end
  end

`ifdef ROLL_REPEAT_EN
  localparam int RMAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int RW   = $clog2(RMAX + 1);
  localparam logic [RW-1:0] R_DELAY_LAST  = RW'(REPEAT_DELAY - 1);
  localparam logic [RW-1:0] R_PERIOD_LAST = RW'(REPEAT_PERIOD - 1);

  logic [RW-1:0] rcnt;
  logic          rfirst;

  // Counts only cycles that stay in HELD; REL_CHK freezes it, IDLE clears it.
  assign rep_fire = (state == HELD) && btn_s &&
                    (rcnt == (rfirst ? R_DELAY_LAST : R_PERIOD_LAST));

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rcnt   <= '0;
      rfirst <= 1'b1;
    end else if (state == IDLE) begin
      rcnt   <= '0;
      rfirst <= 1'b1;
    end else if ((state == HELD) && btn_s) begin
      if (rep_fire) begin
        rcnt   <= '0;
        rfirst <= 1'b0;
      end else begin
        rcnt <= rcnt + 1'b1;
      end
    end
  end
`else
  assign rep_fire = 1'b0;
`endif

endmodule

// File: tb/tb_roll_conditioner.sv
// Directed + randomized bench for roll_conditioner against a run-length debounce model.
module tb_roll_conditioner;
  import dice_pkg::*;

  localparam int D  = 8;
  localparam int RD = 20;
  localparam int RP = 5;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        btn_raw = 1'b1;
  logic        roll;
  logic        btn_level;
  logic [7:0]  press_count;
  roll_state_t state_dbg;

  int checks = 0;
  int errors = 0;

  roll_conditioner #(
    .DEBOUNCE_CYCLES (D),
    .BTN_ACTIVE_LOW  (1),
    .REPEAT_DELAY    (RD),
    .REPEAT_PERIOD   (RP)
  ) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .btn_raw     (btn_raw),
    .roll        (roll),
    .btn_level   (btn_level),
    .press_count (press_count),
    .state_dbg   (state_dbg)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  // Accepted level flips once D+1 consecutive synchronised samples disagree with it.
  logic       m_ff1, m_ff2, s_seen, m_level, m_roll;
  int         m_run, m_held;
  logic [7:0] m_count;
  logic [7:0] exp_q[$];

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      m_ff1 = 1'b1; m_ff2 = 1'b1; m_level = 1'b0; m_roll = 1'b0;
      m_run = 0; m_held = 0; m_count = 8'd0;
      exp_q.delete();
    end else begin
      s_seen = !m_ff2;
      m_ff2  = m_ff1;
      m_ff1  = btn_raw;
      m_roll = 1'b0;
`ifdef ROLL_REPEAT_EN
      if (m_level && m_run == 0 && s_seen) begin
        m_held++;
        if (m_held == RD || (m_held > RD && (m_held - RD) % RP == 0)) begin
          m_roll = 1'b1; m_count++; exp_q.push_back(m_count);
        end
      end
`endif
      if (s_seen != m_level) begin
        m_run++;
        if (m_run == D + 1) begin
          m_level = s_seen;
          m_run   = 0;
          if (m_level) begin
            m_roll = 1'b1; m_count++; exp_q.push_back(m_count);
          end else begin
            m_held = 0;
          end
        end
      end else begin
        m_run = 0;
      end
    end
  end

  // ---------------- checking helpers ----------------
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  int   seg_i, seg_first_roll, seg_rolls, seg_lvl_chg, roll_total;
  logic seg_lvl_start;
  int   roll_at[$];

  task automatic start_seg(input logic raw);
    btn_raw        = raw;
    seg_i          = 0;
    seg_first_roll = -1;
    seg_rolls      = 0;
    seg_lvl_chg    = -1;
    seg_lvl_start  = btn_level;
    roll_at.delete();
  endtask

  task automatic run_cycles(input int n);
    logic [7:0] exp_cnt;
    for (int k = 0; k < n; k++) begin
      @(posedge clk);
      #1;
      chk("roll", roll, m_roll);
      chk("btn_level", btn_level, m_level);
      chk("press_count", press_count, m_count);
      if (roll) begin
        seg_rolls++;
        roll_total++;
        roll_at.push_back(seg_i);
        if (seg_first_roll < 0) seg_first_roll = seg_i;
        chk("sb_nonempty", exp_q.size() != 0, 1);
        if (exp_q.size() != 0) begin
          exp_cnt = exp_q.pop_front();
          chk("sb_count", press_count, exp_cnt);
        end
      end
      if (seg_lvl_chg < 0 && btn_level !== seg_lvl_start) seg_lvl_chg = seg_i;
      seg_i++;
    end
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    btn_raw = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_roll", roll, 0);
    chk("rst_level", btn_level, 0);
    chk("rst_count", press_count, 0);
    reset_n = 1'b1;
  endtask

  // ---------------- stimulus ----------------
  int         before_rolls;
  logic [7:0] before_count;
  logic       raw_v;

  initial begin
    roll_total = 0;
    do_reset();
    start_seg(1'b1);
    run_cycles(5);

    // Clean press and release
    start_seg(1'b0);
    run_cycles(20);
    chk("clean_first_roll", seg_first_roll, 10);
    chk("clean_rolls", seg_rolls, 1);
    chk("clean_level", btn_level, 1);
    chk("clean_count", press_count, 1);
    start_seg(1'b1);
    run_cycles(20);
    chk("clean_rel_latency", seg_lvl_chg, 10);
    chk("clean_rel_level", btn_level, 0);

    // Bounce: toggles every 3 cycles for 30 cycles
    before_rolls = roll_total;
    before_count = press_count;
    for (int t = 0; t < 10; t++) begin
      start_seg(t[0]);
      run_cycles(3);
      chk("bounce_level", btn_level, 0);
    end
    start_seg(1'b1);
    run_cycles(20);
    chk("bounce_rolls", roll_total - before_rolls, 0);
    chk("bounce_count", press_count, before_count);
    chk("bounce_level_end", btn_level, 0);

    // Release glitch
    start_seg(1'b0);
    run_cycles(20);
    chk("glitch_press_roll", seg_rolls, 1);
    before_rolls = roll_total;
    start_seg(1'b1);
    run_cycles(4);
    start_seg(1'b0);
    run_cycles(10);
    chk("glitch_level", btn_level, 1);
    chk("glitch_no_roll", roll_total - before_rolls, 0);
    start_seg(1'b1);
    run_cycles(20);
    chk("glitch_rel_latency", seg_lvl_chg, 10);

    // Random segments
    for (int s = 0; s < 60; s++) begin
      raw_v = 1'($urandom_range(0, 1));
      start_seg(raw_v);
      run_cycles($urandom_range(1, 14));
    end
    start_seg(1'b1);
    run_cycles(24);

    // Wrap: 256 clean presses from reset
    do_reset();
    before_rolls = roll_total;
    for (int p = 0; p < 256; p++) begin
      start_seg(1'b0);
      run_cycles(12);
      start_seg(1'b1);
      run_cycles(12);
    end
    chk("wrap_rolls", roll_total - before_rolls, 256);
    chk("wrap_count", press_count, 0);

    // Reset in the middle of PRESS_CHK with the button still held
    start_seg(1'b0);
    run_cycles(20);
    start_seg(1'b1);
    run_cycles(20);
    start_seg(1'b0);
    run_cycles(6);
    reset_n = 1'b0;
    #1;
    chk("midrst_roll", roll, 0);
    chk("midrst_level", btn_level, 0);
    chk("midrst_count", press_count, 0);
    run_cycles(2);
    reset_n = 1'b1;
    start_seg(1'b0);
    run_cycles(20);
    chk("midrst_first_roll", seg_first_roll, 10);
    chk("midrst_rolls", seg_rolls, 1);

`ifdef ROLL_REPEAT_EN
    // Auto-repeat: acceptance, then +20, +25, +30, +35
    start_seg(1'b1);
    run_cycles(20);
    start_seg(1'b0);
    run_cycles(48);
    chk("rep_pulses", roll_at.size(), 5);
    if (roll_at.size() == 5) begin
      chk("rep_p0", roll_at[0], 10);
      chk("rep_p1", roll_at[1], 30);
      chk("rep_p2", roll_at[2], 35);
      chk("rep_p3", roll_at[3], 40);
      chk("rep_p4", roll_at[4], 45);
    end
    start_seg(1'b1);
    run_cycles(20);
`endif

    chk("sb_drained", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
